// File: rtl/exec_bus_arbiter.sv
// exec_bus_arbiter: shares the peripheral bus between the execute stage and
// the host/debug port. Each transfer is a registered strobe held until the
// slave acks or a timeout expires; the winner gets a one-cycle done pulse
// with read data and an error flag.
module exec_bus_arbiter #(
  parameter int AW             = 8,
  parameter int DW             = 10,
  parameter int TIMEOUT        = 15,
  parameter int EXEC_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // execute stage
  input  logic          ex_req,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  output logic [DW-1:0] ex_rdata,
  output logic          ex_done,
  output logic          ex_err,
  output logic          ex_stall,
  // host / debug port
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_done,
  output logic          hs_err,
  // peripheral bus
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_we,
  output logic          bus_re,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_EX = 2'd1,
    GNT_HS = 2'd2
  } state_t;

  // tmo_cnt only has to reach TIMEOUT-1; burst_cnt has to reach EXEC_BURST_MAX.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (EXEC_BURST_MAX > 0) ? $clog2(EXEC_BURST_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(EXEC_BURST_MAX);

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic [BW-1:0]   burst_cnt;

  logic            any_done;
  logic            ex_cand;
  logic            hs_cand;
  logic            pick_ex;
  logic            pick_hs;
  logic            xfer_end;
  logic [DW-1:0]   rsp_data;

  // The completion cycle is a turnaround cycle: the finishing requester still
  // shows its old req, so nobody is sampled. This keeps a held request from
  // being re-granted and lets a pending host meet a fresh execute request
  // on equal terms, which is what makes the burst limit meaningful.
  assign any_done = ex_done | hs_done;
  assign ex_cand  = ex_req & ~any_done;
  assign hs_cand  = hs_req & ~any_done;

  // Execute wins a tie until it has taken EXEC_BURST_MAX grants in a row
  // against a waiting host.
  assign pick_hs  = hs_cand & (~ex_cand | (burst_cnt == BURST_MAX));
  assign pick_ex  = ex_cand & ~pick_hs;

  // Ack beats the timeout when both land in the same cycle.
  assign xfer_end = bus_ack | (tmo_cnt == TMO_LAST);
  assign rsp_data = (bus_ack & bus_re) ? bus_rdata : '0;

  assign ex_stall = ex_req & ~ex_done;

  // Arbitration FSM with registered bus strobes and per-requester responses.
  // NOTE: every register here is assigned with <= so all of them update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Async clear drops the strobes immediately, even mid-transfer; the
      // aborted transfer simply never completes.
      state     <= IDLE;
      tmo_cnt   <= '0;
      burst_cnt <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      ex_rdata  <= '0;
      ex_done   <= 1'b0;
      ex_err    <= 1'b0;
      hs_rdata  <= '0;
      hs_done   <= 1'b0;
      hs_err    <= 1'b0;
    end else begin
      ex_done <= 1'b0;
      hs_done <= 1'b0;
      ex_err  <= 1'b0;
      hs_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_hs) begin
            state     <= GNT_HS;
            bus_addr  <= hs_addr;
            bus_wdata <= hs_wdata;
            bus_we    <= hs_we;
            bus_re    <= ~hs_we;
            tmo_cnt   <= '0;
            burst_cnt <= '0;
          end else if (pick_ex) begin
            state     <= GNT_EX;
            bus_addr  <= ex_addr;
            bus_wdata <= ex_wdata;
            bus_we    <= ex_we;
            bus_re    <= ~ex_we;
            tmo_cnt   <= '0;
            if (!hs_req) begin
              burst_cnt <= '0;
            end else if (burst_cnt != BURST_MAX) begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
        end

        GNT_EX, GNT_HS: begin
          if (xfer_end) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            if (state == GNT_EX) begin
              ex_done  <= 1'b1;
              ex_err   <= ~bus_ack;
              ex_rdata <= rsp_data;
            end else begin
              hs_done  <= 1'b1;
              hs_err   <= ~bus_ack;
              hs_rdata <= rsp_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_bus_arbiter.sv
// Self-checking bench for exec_bus_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_exec_bus_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 10;
  localparam int TIMEOUT = 15;
  localparam int BURST   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_req, ex_we, hs_req, hs_we, bus_ack;
  logic [AW-1:0] ex_addr, hs_addr;
  logic [DW-1:0] ex_wdata, hs_wdata, bus_rdata;
  logic [DW-1:0] ex_rdata, hs_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          ex_done, ex_err, ex_stall, hs_done, hs_err, bus_we, bus_re;

  int n_assert = 0;
  int n_fail   = 0;

  exec_bus_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .EXEC_BURST_MAX(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_done(ex_done), .ex_err(ex_err), .ex_stall(ex_stall),
    .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_rdata(hs_rdata), .hs_done(hs_done), .hs_err(hs_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    ex_req = 0; ex_we = 0; ex_addr = '0; ex_wdata = '0;
    hs_req = 0; hs_we = 0; hs_addr = '0; hs_wdata = '0;
    bus_ack = 0; bus_rdata = '0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if ({bus_addr, bus_wdata, bus_we, bus_re, ex_done, ex_err, ex_rdata,
         hs_done, hs_err, hs_rdata, ex_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%0h wdata=%0h we=%0b re=%0b exd=%0b hsd=%0b exr=%0h hsr=%0h stall=%0b, all expected 0",
               bus_addr, bus_wdata, bus_we, bus_re, ex_done, hs_done, ex_rdata, hs_rdata, ex_stall);
    end
    rst_n = 1;
    tick();
    tick();
    n_assert++;
    if ({bus_we, bus_re, ex_done, hs_done} !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: we=%0b re=%0b exd=%0b hsd=%0b expected all 0",
               bus_we, bus_re, ex_done, hs_done);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_exec_read;
    int stall_cycles = 0;
    ex_req = 1; ex_we = 0; ex_addr = 8'h12;
    #1;
    if (ex_stall === 1'b1) stall_cycles++;
    tick();
    n_assert++;
    if (bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 8'h12) begin
      n_fail++;
      $display("FAIL exrd_strobe: re=%0b we=%0b addr=%0h expected re=1 we=0 addr=12", bus_re, bus_we, bus_addr);
    end
    if (ex_stall === 1'b1) stall_cycles++;
    bus_ack = 1; bus_rdata = 10'h2A5;
    tick();
    n_assert++;
    if (ex_done !== 1'b1 || ex_rdata !== 10'h2A5 || ex_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exrd_done: done=%0b rdata=%0h err=%0b expected done=1 rdata=2a5 err=0", ex_done, ex_rdata, ex_err);
    end
    n_assert++;
    if (bus_re !== 1'b0 || bus_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL exrd_release: re=%0b addr=%0h expected re=0 addr=0", bus_re, bus_addr);
    end
    if (ex_stall === 1'b1) stall_cycles++;
    bus_ack = 0; ex_req = 0;
    tick();
    if (ex_stall === 1'b1) stall_cycles++;
    n_assert++;
    if (stall_cycles != 2) begin
      n_fail++;
      $display("FAIL exrd_stall_len: stall cycles %0d expected 2", stall_cycles);
    end
    n_assert++;
    if (ex_done !== 1'b0 || ex_rdata !== 10'h2A5) begin
      n_fail++;
      $display("FAIL exrd_hold: done=%0b rdata=%0h expected done=0 rdata=2a5", ex_done, ex_rdata);
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_burst;
    string got = "";
    string want = "EEEEHEEEEH";
    int n = 0;
    int cyc = 0;
    ex_req = 1; ex_we = 0; ex_addr = 8'h01;
    hs_req = 1; hs_we = 0; hs_addr = 8'h02;
    while (cyc < 60 && n < 10) begin
      n_assert++;
      if (ex_done === 1'b1 && hs_done === 1'b1) begin
        n_fail++;
        $display("FAIL burst_one_done: both done pulses high in cycle %0d", cyc);
      end
      if (bus_re === 1'b1 || bus_we === 1'b1) begin
        got = {got, (bus_addr == 8'h01) ? "E" : (bus_addr == 8'h02) ? "H" : "?"};
        n++;
        bus_ack = 1;
      end else begin
        bus_ack = 0;
      end
      tick();
      cyc++;
    end
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL burst_order: grant order %s expected %s", got, want);
    end
    ex_req = 0; hs_req = 0; bus_ack = 0;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_host_write;
    hs_req = 1; hs_we = 1; hs_addr = 8'h40; hs_wdata = 10'h3FF;
    tick();
    n_assert++;
    if (bus_we !== 1'b1 || bus_re !== 1'b0 || bus_addr !== 8'h40 || bus_wdata !== 10'h3FF) begin
      n_fail++;
      $display("FAIL hsw_strobe: we=%0b re=%0b addr=%0h wdata=%0h expected we=1 re=0 addr=40 wdata=3ff",
               bus_we, bus_re, bus_addr, bus_wdata);
    end
    ex_req = 1; ex_we = 0; ex_addr = 8'h55;
    hs_addr = 8'h11; hs_wdata = 10'h000;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_assert++;
      if (bus_we !== 1'b1 || bus_addr !== 8'h40 || bus_wdata !== 10'h3FF) begin
        n_fail++;
        $display("FAIL hsw_hold: we=%0b addr=%0h wdata=%0h expected we=1 addr=40 wdata=3ff",
                 bus_we, bus_addr, bus_wdata);
      end
    end
    bus_ack = 1;
    tick();
    n_assert++;
    if (hs_done !== 1'b1 || hs_err !== 1'b0 || hs_rdata !== 10'h000 || ex_done !== 1'b0) begin
      n_fail++;
      $display("FAIL hsw_done: hsd=%0b err=%0b rdata=%0h exd=%0b expected hsd=1 err=0 rdata=0 exd=0",
               hs_done, hs_err, hs_rdata, ex_done);
    end
    n_assert++;
    if (bus_we !== 1'b0 || bus_re !== 1'b0 || bus_addr !== 8'h00 || bus_wdata !== 10'h000) begin
      n_fail++;
      $display("FAIL hsw_release: we=%0b re=%0b addr=%0h wdata=%0h expected all 0",
               bus_we, bus_re, bus_addr, bus_wdata);
    end
    bus_ack = 0; hs_req = 0;
    tick();
    n_assert++;
    if (bus_re !== 1'b0) begin
      n_fail++;
      $display("FAIL hsw_turnaround: re=%0b expected 0 in the cycle after hs_done", bus_re);
    end
    tick();
    n_assert++;
    if (bus_re !== 1'b1 || bus_addr !== 8'h55) begin
      n_fail++;
      $display("FAIL hsw_ex_next: re=%0b addr=%0h expected re=1 addr=55", bus_re, bus_addr);
    end
    bus_ack = 1; bus_rdata = 10'h155;
    tick();
    n_assert++;
    if (ex_done !== 1'b1 || ex_rdata !== 10'h155) begin
      n_fail++;
      $display("FAIL hsw_ex_done: done=%0b rdata=%0h expected done=1 rdata=155", ex_done, ex_rdata);
    end
    bus_ack = 0; ex_req = 0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_timeout;
    int cnt = 0;
    ex_req = 1; ex_we = 0; ex_addr = 8'h33;
    tick();
    while (bus_re === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_assert++;
    if (cnt != TIMEOUT) begin
      n_fail++;
      $display("FAIL tmo_len: strobe held %0d cycles expected %0d", cnt, TIMEOUT);
    end
    n_assert++;
    if (ex_done !== 1'b1 || ex_err !== 1'b1 || ex_rdata !== 10'h000 || bus_re !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_done: done=%0b err=%0b rdata=%0h re=%0b expected done=1 err=1 rdata=0 re=0",
               ex_done, ex_err, ex_rdata, bus_re);
    end
    ex_req = 0;
    tick();
    // Ack arrives in the last allowed strobe cycle: it must win over the timeout.
    ex_req = 1; ex_addr = 8'h34;
    tick();
    for (int i = 1; i < TIMEOUT; i++) tick();
    n_assert++;
    if (bus_re !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_last_cycle: re=%0b expected 1 in strobe cycle %0d", bus_re, TIMEOUT);
    end
    bus_ack = 1; bus_rdata = 10'h0AB;
    tick();
    n_assert++;
    if (ex_done !== 1'b1 || ex_err !== 1'b0 || ex_rdata !== 10'h0AB) begin
      n_fail++;
      $display("FAIL tmo_ack_wins: done=%0b err=%0b rdata=%0h expected done=1 err=0 rdata=0ab",
               ex_done, ex_err, ex_rdata);
    end
    bus_ack = 0; ex_req = 0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid;
    int done_seen = 0;
    ex_req = 1; ex_we = 0; ex_addr = 8'h66;
    tick();
    n_assert++;
    if (bus_re !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_granted: re=%0b expected 1", bus_re);
    end
    #2 rst_n = 0;
    #1;
    n_assert++;
    if (bus_re !== 1'b0 || bus_addr !== 8'h00 || ex_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: re=%0b addr=%0h done=%0b expected all 0", bus_re, bus_addr, ex_done);
    end
    @(negedge clk);
    if (ex_done === 1'b1) done_seen++;
    rst_n = 1;
    tick();
    if (ex_done === 1'b1) done_seen++;
    n_assert++;
    if (bus_re !== 1'b1 || bus_addr !== 8'h66) begin
      n_fail++;
      $display("FAIL rstmid_regrant: re=%0b addr=%0h expected re=1 addr=66", bus_re, bus_addr);
    end
    n_assert++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: %0d done pulses for the aborted transfer expected 0", done_seen);
    end
    bus_ack = 1; bus_rdata = 10'h066;
    tick();
    n_assert++;
    if (ex_done !== 1'b1 || ex_rdata !== 10'h066) begin
      n_fail++;
      $display("FAIL rstmid_done: done=%0b rdata=%0h expected done=1 rdata=066", ex_done, ex_rdata);
    end
    bus_ack = 0; ex_req = 0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_back_to_back;
    ex_req = 1; ex_we = 1; ex_addr = 8'h77; ex_wdata = 10'h123;
    for (int i = 1; i < 12; i++) begin
      tick();
      n_assert++;
      if (bus_we !== ((i % 3) == 1) || ex_done !== ((i % 3) == 2)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: we=%0b done=%0b expected we=%0b done=%0b",
                 i, bus_we, ex_done, (i % 3) == 1, (i % 3) == 2);
      end
      bus_ack = bus_we;
    end
    ex_req = 0; bus_ack = 0;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Reference model: one outstanding transaction at most, recorded as who
  // owns the bus, what was latched at grant, and how long it has waited.
  int            m_owner;   // 0 none, 1 execute, 2 host
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_we;
  int            m_wait;
  int            m_burst;
  bit            m_exd, m_hsd, m_exe, m_hse;
  logic [DW-1:0] m_exr, m_hsr;

  task automatic model_step;
    bit grant_hs;
    bit n_exd = 0;
    bit n_hsd = 0;
    logic [DW-1:0] res;
    if (m_owner == 0) begin
      if (!m_exd && !m_hsd && (ex_req || hs_req)) begin
        grant_hs = hs_req && (!ex_req || m_burst == BURST);
        if (grant_hs) begin
          m_owner = 2; m_addr = hs_addr; m_wdata = hs_wdata; m_we = hs_we;
          m_burst = 0;
        end else begin
          m_owner = 1; m_addr = ex_addr; m_wdata = ex_wdata; m_we = ex_we;
          m_burst = hs_req ? ((m_burst < BURST) ? m_burst + 1 : BURST) : 0;
        end
        m_wait = 0;
      end
    end else if (bus_ack || m_wait == TIMEOUT - 1) begin
      res = (bus_ack && !m_we) ? bus_rdata : '0;
      if (m_owner == 1) begin n_exd = 1; m_exe = !bus_ack; m_exr = res; end
      else              begin n_hsd = 1; m_hse = !bus_ack; m_hsr = res; end
      m_owner = 0;
    end else begin
      m_wait++;
    end
    m_exd = n_exd;
    m_hsd = n_hsd;
  endtask

  task automatic test_random;
    bit dead = 0;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int n_done = 0;
    rst_n = 0;
    clear_inputs();
    tick();
    rst_n = 1;
    m_owner = 0; m_addr = '0; m_wdata = '0; m_we = 0; m_wait = 0; m_burst = 0;
    m_exd = 0; m_hsd = 0; m_exe = 0; m_hse = 0; m_exr = '0; m_hsr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_addr = (m_owner != 0) ? m_addr : '0;
      e_data = (m_owner != 0) ? m_wdata : '0;
      n_assert++;
      if (bus_re !== (m_owner != 0 && !m_we) || bus_we !== (m_owner != 0 && m_we) ||
          bus_addr !== e_addr || bus_wdata !== e_data) begin
        n_fail++;
        $display("FAIL rnd_bus c%0d: re=%0b we=%0b addr=%0h wdata=%0h expected re=%0b we=%0b addr=%0h wdata=%0h",
                 cyc, bus_re, bus_we, bus_addr, bus_wdata,
                 m_owner != 0 && !m_we, m_owner != 0 && m_we, e_addr, e_data);
      end
      n_assert++;
      if (ex_done !== m_exd || hs_done !== m_hsd || ex_rdata !== m_exr || hs_rdata !== m_hsr ||
          (m_exd && ex_err !== m_exe) || (m_hsd && hs_err !== m_hse)) begin
        n_fail++;
        $display("FAIL rnd_rsp c%0d: exd=%0b exr=%0h exe=%0b hsd=%0b hsr=%0h hse=%0b expected exd=%0b exr=%0h exe=%0b hsd=%0b hsr=%0h hse=%0b",
                 cyc, ex_done, ex_rdata, ex_err, hs_done, hs_rdata, hs_err,
                 m_exd, m_exr, m_exe, m_hsd, m_hsr, m_hse);
      end
      n_assert++;
      if (ex_stall !== (ex_req && !m_exd)) begin
        n_fail++;
        $display("FAIL rnd_stall c%0d: stall=%0b expected %0b", cyc, ex_stall, ex_req && !m_exd);
      end
      if (m_exd) n_done++;
      if (m_hsd) n_done++;

      // Execute agent: holds a request until its done, then may chain another.
      if (m_exd || !ex_req) begin
        if ($urandom_range(0, 3) < (m_exd ? 2 : 1)) begin
          ex_req = 1; ex_we = 1'($urandom); ex_addr = AW'($urandom); ex_wdata = DW'($urandom);
        end else begin
          ex_req = 0;
        end
      end else if (m_owner == 1) begin
        ex_we = 1'($urandom); ex_addr = AW'($urandom); ex_wdata = DW'($urandom);
      end
      // Host agent, same rules.
      if (m_hsd || !hs_req) begin
        if ($urandom_range(0, 3) < (m_hsd ? 2 : 1)) begin
          hs_req = 1; hs_we = 1'($urandom); hs_addr = AW'($urandom); hs_wdata = DW'($urandom);
        end else begin
          hs_req = 0;
        end
      end else if (m_owner == 2) begin
        hs_we = 1'($urandom); hs_addr = AW'($urandom); hs_wdata = DW'($urandom);
      end
      // Slave: random ack delay, occasionally never acks; stray acks when idle.
      if (m_owner != 0) begin
        if (m_wait == 0) dead = ($urandom_range(0, 5) == 0);
        bus_ack = !dead && ($urandom_range(0, 2) == 0);
      end else begin
        bus_ack = ($urandom_range(0, 7) == 0);
      end
      bus_rdata = DW'($urandom);

      model_step();
      tick();
    end
    n_assert++;
    if (n_done < 20) begin
      n_fail++;
      $display("FAIL rnd_progress: only %0d completions in the random run", n_done);
    end
    clear_inputs();
    tick();
  endtask

  // ---------------------------------------------------------------------
  initial begin
    clear_inputs();
    test_reset();
    test_exec_read();
    test_burst();
    test_host_write();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
